avalon_to_wb_burst_bridge: RTL and testbench

Parametrised Avalon-MM slave to Wishbone B4 master bridge that converts Avalon burst reads and writes into Wishbone incrementing-address bursts. It replaces the single-beat bridge between the ao486 memory/IO Avalon ports and the SoC Wishbone fabric. The CPU's burst requests (up to 8 beats) therefore reach memory as registered-feedback bursts instead of separate classic cycles.

---
 rtl/avalon_to_wb_burst_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_avalon_to_wb_burst_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_to_wb_burst_bridge.sv
// Avalon-MM slave to Wishbone B4 master bridge: Avalon bursts become incrementing WB bursts.
// Define AV_WB_BURST_EN for registered-feedback bursts (cti 010/111); otherwise each beat is a classic cycle.
module avalon_to_wb_burst_bridge #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned BCW = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [AW-1:0]     s_av_address_i,
  input  logic [DW/8-1:0]   s_av_byteenable_i,
  input  logic [BCW-1:0]    s_av_burstcount_i,
  input  logic              s_av_read_i,
  input  logic              s_av_write_i,
  input  logic [DW-1:0]     s_av_writedata_i,
  output logic [DW-1:0]     s_av_readdata_o,
  output logic              s_av_readdatavalid_o,
  output logic              s_av_waitrequest_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  output logic [DW/8-1:0]   wbm_sel_o,
  output logic              wbm_we_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic [2:0]        wbm_cti_o,
  output logic [1:0]        wbm_bte_o,
  input  logic [DW-1:0]     wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  input  logic              wbm_rty_i,
  output logic              bus_err_o
);

  localparam int unsigned BW = DW / 8;

`ifdef AV_WB_BURST_EN
  localparam logic BURST_EN = 1'b1;
`else
  localparam logic BURST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD, WR, WR_WAIT} state_t;

  state_t           state_q, state_n;
  logic [AW-1:0]    adr_q, adr_n;
  logic [DW-1:0]    dat_q, dat_n;
  logic [BW-1:0]    sel_q, sel_n;
  logic             we_q, we_n;
  logic             cyc_q, cyc_n;
  logic             stb_q, stb_n;
  logic [2:0]       cti_q, cti_n;
  logic [BCW-1:0]   cnt_q, cnt_n;
  logic [DW-1:0]    rdata_q, rdata_n;
  logic             rvalid_q, rvalid_n;
  logic             berr_q, berr_n;

  logic             beat_done, beat_err, last_beat;
  logic [BCW-1:0]   cnt_dec, accept_cnt;
  logic [AW-1:0]    adr_inc;

  function automatic logic [2:0] cti_for(input logic [BCW-1:0] remaining);
    if (!BURST_EN)
      return 3'b000;
    return (remaining > BCW'(1)) ? 3'b010 : 3'b111;
  endfunction

  // err wins over ack; rty alone holds the beat for a retry
  assign beat_done  = stb_q && (wbm_err_i || (wbm_ack_i && !wbm_rty_i));
  assign beat_err   = stb_q && wbm_err_i;
  assign last_beat  = (cnt_q == BCW'(1));
  assign cnt_dec    = cnt_q - BCW'(1);
  assign adr_inc    = adr_q + AW'(BW);
  assign accept_cnt = (s_av_burstcount_i == '0) ? BCW'(1) : s_av_burstcount_i;

  always_comb begin
    state_n            = state_q;
    adr_n              = adr_q;
    dat_n              = dat_q;
    sel_n              = sel_q;
    we_n               = we_q;
    cyc_n              = cyc_q;
    stb_n              = stb_q;
    cti_n              = cti_q;
    cnt_n              = cnt_q;
    rdata_n            = rdata_q;
    rvalid_n           = 1'b0;
    berr_n             = 1'b0;
    s_av_waitrequest_o = 1'b1;

    unique case (state_q)
      IDLE: begin
        s_av_waitrequest_o = !(s_av_read_i || s_av_write_i);
        if (s_av_read_i || s_av_write_i) begin
          adr_n   = s_av_address_i;
          sel_n   = s_av_byteenable_i;
          cnt_n   = accept_cnt;
          we_n    = !s_av_read_i;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          cti_n   = cti_for(accept_cnt);
          if (s_av_read_i) begin
            state_n = RD;
          end else begin
            dat_n   = s_av_writedata_i;
            state_n = WR;
          end
        end
      end

      RD: begin
        if (beat_done) begin
          rdata_n  = beat_err ? '0 : wbm_dat_i;
          rvalid_n = 1'b1;
          berr_n   = beat_err;
          if (last_beat) begin
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            cti_n   = '0;
            state_n = IDLE;
          end else begin
            adr_n = adr_inc;
            cnt_n = cnt_dec;
            cti_n = cti_for(cnt_dec);
            cyc_n = BURST_EN;
            stb_n = BURST_EN;
          end
        end else if (!stb_q) begin
          // classic mode: relaunch after the one-cycle idle gap
          cyc_n = 1'b1;
          stb_n = 1'b1;
        end
      end

      WR: begin
        if (beat_done) begin
          berr_n = beat_err;
          if (last_beat) begin
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            cti_n   = '0;
            state_n = IDLE;
          end else begin
            stb_n   = 1'b0;
            cyc_n   = BURST_EN;
            adr_n   = adr_inc;
            cnt_n   = cnt_dec;
            cti_n   = cti_for(cnt_dec);
            state_n = WR_WAIT;
          end
        end
      end

      WR_WAIT: begin
        s_av_waitrequest_o = 1'b0;
        if (s_av_write_i) begin
          dat_n   = s_av_writedata_i;
          sel_n   = s_av_byteenable_i;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          state_n = WR;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      cti_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      adr_q    <= adr_n;
      dat_q    <= dat_n;
      sel_q    <= sel_n;
      we_q     <= we_n;
      cyc_q    <= cyc_n;
      stb_q    <= stb_n;
      cti_q    <= cti_n;
      cnt_q    <= cnt_n;
      rdata_q  <= rdata_n;
      rvalid_q <= rvalid_n;
      berr_q   <= berr_n;
    end
  end

  assign wbm_adr_o            = adr_q;
  assign wbm_dat_o            = dat_q;
  assign wbm_sel_o            = sel_q;
  assign wbm_we_o             = we_q;
  assign wbm_cyc_o            = cyc_q;
  assign wbm_stb_o            = stb_q;
  assign wbm_cti_o            = cti_q;
  assign wbm_bte_o            = 2'b00;
  assign s_av_readdata_o      = rdata_q;
  assign s_av_readdatavalid_o = rvalid_q;
  assign bus_err_o            = berr_q;

endmodule

// File: tb/tb_avalon_to_wb_burst_bridge.sv
// Bench for avalon_to_wb_burst_bridge: transaction-level expected-beat model plus a scripted WB slave.
module tb_avalon_to_wb_burst_bridge;

`ifdef AV_WB_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_av_address_i;
  logic [3:0]  s_av_byteenable_i;
  logic [7:0]  s_av_burstcount_i;
  logic        s_av_read_i, s_av_write_i;
  logic [31:0] s_av_writedata_i;
  logic [31:0] s_av_readdata_o;
  logic        s_av_readdatavalid_o, s_av_waitrequest_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic        bus_err_o;

  always #5 clk = ~clk;

  avalon_to_wb_burst_bridge #(.AW(32), .DW(32), .BCW(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s_av_address_i(s_av_address_i), .s_av_byteenable_i(s_av_byteenable_i),
    .s_av_burstcount_i(s_av_burstcount_i), .s_av_read_i(s_av_read_i),
    .s_av_write_i(s_av_write_i), .s_av_writedata_i(s_av_writedata_i),
    .s_av_readdata_o(s_av_readdata_o), .s_av_readdatavalid_o(s_av_readdatavalid_o),
    .s_av_waitrequest_o(s_av_waitrequest_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wbm_rty_i(wbm_rty_i), .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [2:0]  cti;
    int          waits;
    int          rtys;
    bit          err;
    bit          last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] obs_adr[$], obs_dat[$], obs_rd[$];
  logic [2:0]  obs_cti[$];
  int          stb_cycles, rv_cnt, berr_cnt, cyc_no, first_rv, last_rv;
  bit          pend_rv;
  int          n_cmp = 0, n_bad = 0;

  int          sw[8], sr[8];
  bit          se[8];
  logic [31:0] wdat[8];
  logic [3:0]  wbe[8];
  int          stalls[8];

  // Slave read data is a fixed function of the address it is presented with
  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave responder and per-cycle comparison against the expected-beat queue
  initial begin
    bit          rst_e, pend_err, pend_cyc;
    logic        exp_cyc;
    logic [31:0] pend_dat;
    beat_t       h;
    pend_rv = 0; pend_err = 0; pend_cyc = 0; exp_cyc = 0; pend_dat = '0;
    forever begin
      @(posedge clk);
      rst_e = rst;
      #1;
      cyc_no++;
      wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0; wbm_dat_i = 32'hDEAD_BEEF;
      if (rst_e) begin
        exp_q.delete();
        pend_rv = 0; pend_err = 0; pend_cyc = 0;
        check("rst_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
        check("rst_rvalid_berr", {s_av_readdatavalid_o, bus_err_o}, 0);
        continue;
      end
      check("readdatavalid", s_av_readdatavalid_o, pend_rv);
      if (pend_rv && s_av_readdatavalid_o) check("readdata", s_av_readdata_o, pend_dat);
      if (s_av_readdatavalid_o) begin
        obs_rd.push_back(s_av_readdata_o);
        rv_cnt++;
        if (rv_cnt == 1) first_rv = cyc_no;
        last_rv = cyc_no;
      end
      check("bus_err", bus_err_o, pend_err);
      if (bus_err_o) berr_cnt++;
      if (pend_cyc) check("cyc_after_beat", wbm_cyc_o, exp_cyc);
      pend_rv = 0; pend_err = 0; pend_cyc = 0;

      if (exp_q.size() == 0) begin
        check("idle_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
      end else if (wbm_stb_o) begin
        h = exp_q[0];
        stb_cycles++;
        check("stb_cyc", wbm_cyc_o, 1);
        check("wb_adr", wbm_adr_o, h.adr);
        check("wb_we", wbm_we_o, h.we);
        check("wb_sel", wbm_sel_o, h.sel);
        check("wb_cti", wbm_cti_o, h.cti);
        check("wb_bte", wbm_bte_o, 0);
        if (h.we) check("wb_dat", wbm_dat_o, h.dat);
        if (h.waits > 0) begin
          h.waits--;
          exp_q[0] = h;
        end else if (h.rtys > 0) begin
          h.rtys--;
          exp_q[0] = h;
          wbm_rty_i = 1;
        end else begin
          if (h.err) wbm_err_i = 1; else wbm_ack_i = 1;
          wbm_dat_i = rd_pat(wbm_adr_o);
          obs_adr.push_back(wbm_adr_o);
          obs_dat.push_back(wbm_dat_o);
          obs_cti.push_back(wbm_cti_o);
          if (!h.we) begin
            pend_rv  = 1;
            pend_dat = h.err ? 32'h0 : rd_pat(h.adr);
          end
          pend_err = h.err;
          pend_cyc = 1;
          exp_cyc  = h.last ? 1'b0 : BURST;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic clr_script();
    for (int i = 0; i < 8; i++) begin
      sw[i] = 0; sr[i] = 0; se[i] = 0; stalls[i] = -1;
    end
  endtask

  task automatic clr_obs();
    obs_adr.delete(); obs_dat.delete(); obs_rd.delete(); obs_cti.delete();
    stb_cycles = 0; rv_cnt = 0; berr_cnt = 0; first_rv = 0; last_rv = 0;
  endtask

  task automatic push_beats(input logic [31:0] base, input int n, input bit we, input logic [3:0] be);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.adr   = base + 32'(4 * i);
      b.we    = we;
      b.sel   = we ? wbe[i] : be;
      b.dat   = we ? wdat[i] : 32'h0;
      b.cti   = BURST ? ((i == n - 1) ? 3'b111 : 3'b010) : 3'b000;
      b.waits = sw[i];
      b.rtys  = sr[i];
      b.err   = se[i];
      b.last  = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !pend_rv) begin
        ok = 1;
        break;
      end
    end
    @(negedge clk);
    if (!ok) check("wait_idle_timeout", 0, 1);
  endtask

  task automatic av_read(input logic [31:0] addr, input logic [7:0] bc, input logic [3:0] be, input bit wait_done);
    int n = (bc == 0) ? 1 : int'(bc);
    @(negedge clk);
    push_beats(addr, n, 1'b0, be);
    s_av_address_i = addr; s_av_byteenable_i = be; s_av_burstcount_i = bc; s_av_read_i = 1;
    #1 check("wreq_idle_read", s_av_waitrequest_o, 0);
    @(posedge clk);
    @(negedge clk);
    s_av_read_i = 0; s_av_address_i = 32'hBAD0_0000; s_av_burstcount_i = 8'hFF;
    #1 check("wreq_busy_read", s_av_waitrequest_o, 1);
    if (wait_done) wait_idle();
  endtask

  task automatic av_write(input logic [31:0] addr, input logic [7:0] bc);
    int n = (bc == 0) ? 1 : int'(bc);
    int st;
    @(negedge clk);
    push_beats(addr, n, 1'b1, 4'h0);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      s_av_write_i = 1; s_av_writedata_i = wdat[k]; s_av_byteenable_i = wbe[k];
      s_av_address_i = (k == 0) ? addr : 32'hBAD0_0000; s_av_burstcount_i = bc;
      #1;
      st = 0;
      while (s_av_waitrequest_o && st < 50) begin
        @(negedge clk);
        #1;
        st++;
      end
      if (st >= 50) check("write_accept_timeout", 0, 1);
      stalls[k] = st;
      @(posedge clk);
    end
    @(negedge clk);
    s_av_write_i = 0;
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1;
    s_av_address_i = '0; s_av_byteenable_i = '0; s_av_burstcount_i = '0;
    s_av_read_i = 0; s_av_write_i = 0; s_av_writedata_i = '0;
    wbm_dat_i = '0; wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
    clr_script();
    clr_obs();
    repeat (3) @(negedge clk);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat_sel_we", {wbm_dat_o, wbm_sel_o, wbm_we_o}, 0);
    check("rst_cti_bte", {wbm_cti_o, wbm_bte_o}, 0);
    check("rst_readdata", s_av_readdata_o, 0);
    rst = 0;
    @(negedge clk);
    #1 check("wreq_no_cmd", s_av_waitrequest_o, 1);

    // single read, two wait states
    clr_script(); clr_obs();
    sw[0] = 2;
    av_read(32'h0000_0100, 8'd1, 4'hF, 1);
    check("t1_adr", obs_adr[0], 32'h0000_0100);
    check("t1_cti", obs_cti[0], BURST ? 3'b111 : 3'b000);
    check("t1_stb_cycles", stb_cycles, 3);
    check("t1_rv_cnt", rv_cnt, 1);
    check("t1_rdata", obs_rd[0], 32'h0100_FEFF);

    // 8-beat zero-wait read
    clr_script(); clr_obs();
    av_read(32'h0000_1000, 8'd8, 4'hF, 1);
    check("t2_rv_cnt", rv_cnt, 8);
    check("t2_last_adr", obs_adr[7], 32'h0000_101C);
    check("t2_rv_span", last_rv - first_rv, BURST ? 7 : 14);

    // 4-beat write A..D
    clr_script(); clr_obs();
    wdat[0] = 32'hAAAA_0001; wdat[1] = 32'hBBBB_0002; wdat[2] = 32'hCCCC_0003; wdat[3] = 32'hDDDD_0004;
    for (int i = 0; i < 4; i++) wbe[i] = 4'hF;
    av_write(32'h0000_0500, 8'd4);
    check("t3_wr_cnt", obs_adr.size(), 4);
    check("t3_last_adr", obs_adr[3], 32'h0000_050C);
    check("t3_last_dat", obs_dat[3], 32'hDDDD_0004);
    check("t3_stall0", stalls[0], 0);
    for (int i = 1; i < 4; i++) check("t3_stall", stalls[i], 1);

    // rty on beat 2, err on beat 3
    clr_script(); clr_obs();
    sr[1] = 1; se[2] = 1;
    av_read(32'h0000_2000, 8'd4, 4'h3, 1);
    check("t4_rv_cnt", rv_cnt, 4);
    check("t4_berr_cnt", berr_cnt, 1);
    check("t4_stb_cycles", stb_cycles, 5);
    check("t4_beat2_adr", obs_adr[1], 32'h0000_2004);
    check("t4_beat2_rdata", obs_rd[1], 32'h2004_DFFB);
    check("t4_beat3_rdata", obs_rd[2], 32'h0);

    // reset mid-burst after three acks
    clr_script(); clr_obs();
    sw[3] = 5;
    av_read(32'h0000_3000, 8'd8, 4'hF, 0);
    for (int c = 0; c < 100 && obs_adr.size() < 3; c++) @(negedge clk);
    check("t5_three_acks", obs_adr.size(), 3);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("t5_cyc_dropped", wbm_cyc_o, 0);
    repeat (4) @(negedge clk);
    check("t5_rv_cnt", rv_cnt, 3);
    clr_script(); clr_obs();
    av_read(32'h0000_0200, 8'd0, 4'hF, 1);
    check("t5_new_rv_cnt", rv_cnt, 1);
    check("t5_new_rdata", obs_rd[0], 32'h0200_FDFF);

    // address wrap
    clr_script(); clr_obs();
    av_read(32'hFFFF_FFFC, 8'd2, 4'hF, 1);
    check("t6_adr0", obs_adr[0], 32'hFFFF_FFFC);
    check("t6_adr1", obs_adr[1], 32'h0000_0000);
    check("t6_rdata1", obs_rd[1], 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
